// File: rtl/debounced_updown_counter.sv
// Three raw push-buttons (up/down/clear) are synchronised, debounced and edge-detected
// to drive a modulo or saturating up/down counter. Optional auto-repeat: AUTOREPEAT_EN.
module debounced_updown_counter #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned MAX_COUNT       = 255,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WRAP            = 1,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_key_up,
  input  logic             i_key_down,
  input  logic             i_key_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_step,
  output logic             o_limit
);

  localparam int unsigned NKEY = 3;
  localparam int unsigned KCLR = 2;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX_COUNT);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      (WIDTH < 32 && (MAX_COUNT >> WIDTH) != 0)) begin : g_bad_cfg
    $error("debounced_updown_counter: illegal parameter set");
  end

  logic [NKEY-1:0] w_key_raw;
  logic [NKEY-1:0] r_sync1, r_sync2, r_level;
  logic [DB_W-1:0] r_db_cnt [NKEY];
  logic [NKEY-1:0] w_flip, w_rise;
  logic [1:0]      w_ev_ud;

  assign w_key_raw = {i_key_clr, i_key_down, i_key_up};

  // The press event fires on the edge the debounced level rises, so the count
  // updates in the same edge rather than one later.
  always_comb begin
    for (int k = 0; k < NKEY; k++) begin
      w_flip[k] = (r_sync2[k] != r_level[k]) && (r_db_cnt[k] == DB_LAST);
      w_rise[k] = w_flip[k] && r_sync2[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int k = 0; k < NKEY; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < NKEY; k++) begin
        if (r_sync2[k] == r_level[k]) begin
          r_db_cnt[k] <= '0;
        end else if (w_flip[k]) begin
          r_level[k]  <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_REPEAT = 2'd2} rpt_state_e;

  rpt_state_e       r_state [2];
  rpt_state_e       w_state_nxt [2];
  logic [TMR_W-1:0] r_timer [2];
  logic [TMR_W-1:0] w_timer_nxt [2];
  logic [1:0]       w_rep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= S_IDLE;
        r_timer[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_timer[k] <= w_timer_nxt[k];
      end
    end
  end

  // Per up/down key: IDLE -> HOLD on press, HOLD -> REPEAT after the hold delay.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_state_nxt[k] = r_state[k];
      w_timer_nxt[k] = r_timer[k] + TMR_W'(1);
      if (w_rise[KCLR]) begin
        w_state_nxt[k] = S_IDLE;
        w_timer_nxt[k] = '0;
      end else begin
        case (r_state[k])
          S_IDLE: begin
            w_timer_nxt[k] = '0;
            if (w_rise[k]) w_state_nxt[k] = S_HOLD;
          end
          S_HOLD: begin
            if (!r_level[k]) begin
              w_state_nxt[k] = S_IDLE;
              w_timer_nxt[k] = '0;
            end else if (r_timer[k] == HOLD_LAST) begin
              w_state_nxt[k] = S_REPEAT;
              w_timer_nxt[k] = '0;
            end
          end
          S_REPEAT: begin
            if (!r_level[k]) begin
              w_state_nxt[k] = S_IDLE;
              w_timer_nxt[k] = '0;
            end else if (r_timer[k] == REP_LAST) begin
              w_timer_nxt[k] = '0;
            end
          end
          default: begin
            w_state_nxt[k] = S_IDLE;
            w_timer_nxt[k] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_rep = '0;
    for (int k = 0; k < 2; k++) begin
      case (r_state[k])
        S_HOLD:   w_rep[k] = r_level[k] && (r_timer[k] == HOLD_LAST);
        S_REPEAT: w_rep[k] = r_level[k] && (r_timer[k] == REP_LAST);
        default:  w_rep[k] = 1'b0;
      endcase
    end
  end

  assign w_ev_ud = w_rise[1:0] | w_rep;
`else
  assign w_ev_ud = w_rise[1:0];
`endif

  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_step, r_limit, w_step_nxt, w_limit_nxt;

  // Priority: clear, then up+down cancel, then up, then down.
  always_comb begin
    w_count_nxt = r_count;
    w_step_nxt  = 1'b0;
    w_limit_nxt = 1'b0;
    if (w_rise[KCLR]) begin
      w_count_nxt = '0;
      w_step_nxt  = 1'b1;
    end else if (w_ev_ud == 2'b11) begin
      w_count_nxt = r_count;
    end else if (w_ev_ud[0]) begin
      if (r_count >= CNT_MAX) begin
        w_limit_nxt = 1'b1;
        if (WRAP != 0) begin
          w_count_nxt = '0;
          w_step_nxt  = 1'b1;
        end
      end else begin
        w_count_nxt = r_count + WIDTH'(1);
        w_step_nxt  = 1'b1;
      end
    end else if (w_ev_ud[1]) begin
      if (r_count == '0) begin
        w_limit_nxt = 1'b1;
        if (WRAP != 0) begin
          w_count_nxt = CNT_MAX;
          w_step_nxt  = 1'b1;
        end
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
        w_step_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_step  <= 1'b0;
      r_limit <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_step  <= w_step_nxt;
      r_limit <= w_limit_nxt;
    end
  end

  assign o_count = r_count;
  assign o_step  = r_step;
  assign o_limit = r_limit;

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Bench for debounced_updown_counter: a wrapping and a saturating instance share the
// same keys; directed vectors with hand-computed results plus multi-cycle sequences.
module tb_debounced_updown_counter;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic             up, down, clr;
    logic [WIDTH-1:0] w_cnt;
    logic             w_step, w_lim;
    logic [WIDTH-1:0] s_cnt;
    logic             s_step, s_lim;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_up, key_down, key_clr;
  logic [WIDTH-1:0] cnt_w, cnt_s;
  logic             step_w, step_s, lim_w, lim_s;
  logic [WIDTH-1:0] exp_w, exp_s;
  int               checks = 0;
  int               errors = 0;

  always #5 clk = ~clk;

  debounced_updown_counter #(
    .WIDTH(WIDTH), .MAX_COUNT(9), .DEBOUNCE_CYCLES(4), .WRAP(1),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_wrap (
    .clk(clk), .rst(rst), .i_key_up(key_up), .i_key_down(key_down), .i_key_clr(key_clr),
    .o_count(cnt_w), .o_step(step_w), .o_limit(lim_w)
  );

  debounced_updown_counter #(
    .WIDTH(WIDTH), .MAX_COUNT(9), .DEBOUNCE_CYCLES(4), .WRAP(0),
    .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
  ) u_sat (
    .clk(clk), .rst(rst), .i_key_up(key_up), .i_key_down(key_down), .i_key_clr(key_clr),
    .o_count(cnt_s), .o_step(step_s), .o_limit(lim_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compares {count, step, limit} of both instances.
  task automatic expect_both(input string tag,
                             input logic [WIDTH-1:0] cw, input logic sw, input logic lw,
                             input logic [WIDTH-1:0] cs, input logic ss, input logic ls);
    chk({tag, "_wrap"}, {22'd0, cnt_w, step_w, lim_w}, {22'd0, cw, sw, lw});
    chk({tag, "_sat"},  {22'd0, cnt_s, step_s, lim_s}, {22'd0, cs, ss, ls});
  endtask

  function automatic vec_t mk(input logic u, input logic d, input logic c,
                              input logic [WIDTH-1:0] wc, input logic ws, input logic wl,
                              input logic [WIDTH-1:0] sc, input logic ss, input logic sl);
    vec_t v;
    v.up = u; v.down = d; v.clr = c;
    v.w_cnt = wc; v.w_step = ws; v.w_lim = wl;
    v.s_cnt = sc; v.s_step = ss; v.s_lim = sl;
    return v;
  endfunction

  // Press keys, check exact event latency (6th edge), pulse width, then release.
  task automatic press(input int idx, input vec_t v);
    key_up = v.up; key_down = v.down; key_clr = v.clr;
    for (int t = 1; t <= 5; t++) begin
      tick();
      expect_both($sformatf("v%0d_pre", idx), exp_w, 1'b0, 1'b0, exp_s, 1'b0, 1'b0);
    end
    tick();
    expect_both($sformatf("v%0d_event", idx), v.w_cnt, v.w_step, v.w_lim,
                v.s_cnt, v.s_step, v.s_lim);
    exp_w = v.w_cnt;
    exp_s = v.s_cnt;
    tick();
    expect_both($sformatf("v%0d_post", idx), exp_w, 1'b0, 1'b0, exp_s, 1'b0, 1'b0);
    key_up = 1'b0; key_down = 1'b0; key_clr = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      expect_both($sformatf("v%0d_release", idx), exp_w, 1'b0, 1'b0, exp_s, 1'b0, 1'b0);
    end
  endtask

  vec_t vq[$];
  logic ev;

  initial begin
    // Reset with up held; the held key counts as a fresh press 6 edges after release.
    rst = 1'b0; key_up = 1'b1; key_down = 1'b0; key_clr = 1'b0;
    exp_w = '0; exp_s = '0;
    repeat (3) tick();
    expect_both("reset", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    vq.push_back(mk(1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0));
    rst = 1'b1;
    press(0, vq.pop_front());

    vq.push_back(mk(0,0,1, 8'd0,1,0, 8'd0,1,0));   // clear at 1
    vq.push_back(mk(0,1,0, 8'd9,1,1, 8'd0,0,1));   // down at 0
    vq.push_back(mk(0,0,1, 8'd0,1,0, 8'd0,1,0));
    for (int i = 1; i <= 9; i++)
      vq.push_back(mk(1,0,0, 8'(i),1,0, 8'(i),1,0));
    vq.push_back(mk(1,0,0, 8'd0,1,1, 8'd9,0,1));   // up at MAX
    vq.push_back(mk(1,1,0, 8'd0,0,0, 8'd9,0,0));   // up+down cancel
    vq.push_back(mk(0,1,0, 8'd9,1,1, 8'd8,1,0));
    vq.push_back(mk(0,1,0, 8'd8,1,0, 8'd7,1,0));
    vq.push_back(mk(1,0,0, 8'd9,1,0, 8'd8,1,0));
    vq.push_back(mk(0,1,0, 8'd8,1,0, 8'd7,1,0));
    vq.push_back(mk(0,1,0, 8'd7,1,0, 8'd6,1,0));
    vq.push_back(mk(0,1,0, 8'd6,1,0, 8'd5,1,0));
    vq.push_back(mk(0,1,0, 8'd5,1,0, 8'd4,1,0));
    vq.push_back(mk(1,0,1, 8'd0,1,0, 8'd0,1,0));   // up+clr at 5
    vq.push_back(mk(0,0,1, 8'd0,1,0, 8'd0,1,0));   // clear when already 0
    for (int i = 0; i < vq.size(); i++) press(i + 1, vq[i]);

    // Bouncing press: 1,0,1,1,0 then steady 1 -> one increment at fixed latency.
    key_up = 1'b1; tick(); key_up = 1'b0; tick(); key_up = 1'b1; tick();
    tick(); key_up = 1'b0; tick();
    expect_both("bounce_early", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    press(100, mk(1,0,0, 8'd1,1,0, 8'd1,1,0));

    // Three-cycle clear glitch must be ignored.
    key_clr = 1'b1;
    repeat (3) tick();
    key_clr = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      expect_both($sformatf("glitch_t%0d", t), 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    end

    // Long hold of up: single event, or auto-repeat at +20, +25, ... when enabled.
    key_up = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      tick();
      ev = (t == 6);
`ifdef AUTOREPEAT_EN
      if (t >= 26 && ((t - 26) % 5) == 0) ev = 1'b1;
`endif
      if (ev) begin
        exp_w = exp_w + 8'd1;
        exp_s = exp_s + 8'd1;
      end
      expect_both($sformatf("hold_t%0d", t), exp_w, ev, 1'b0, exp_s, ev, 1'b0);
    end
    key_up = 1'b0;
    repeat (15) tick();
`ifndef AUTOREPEAT_EN
    expect_both("hold_end", 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-press; held key re-debounced after release.
    key_up = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #2;
    expect_both("async_rst", 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    exp_w = '0; exp_s = '0;
    press(200, mk(1,0,0, 8'd1,1,0, 8'd1,1,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
